vbram_port_arbiter: RTL and testbench
=====================================

Name: vbram_port_arbiter

Overview:
- Shares one true-dual-port block RAM (single clock, no-change mode, output register enabled, 2-cycle read latency) among NREQ requesters, e.g. vector lanes or load/store units.
- Each cycle, round-robin arbitration grants up to two requests: the first winner goes to RAM port A, the second to port B.
- All RAM control signals are registered.
- Read data returns to the issuing requester with a fixed latency and a per-requester valid strobe.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 72, RAM data width.
- DEPTH, 2048, RAM depth; derived localparam AW = ceil(log2(DEPTH)) is the address width.

Ports:
- clka  in  1  clock for the arbiter and both RAM ports.
- rstb  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  grant; a request is accepted when valid and ready are both high.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- req_wdata  in  NREQ*WIDTH  packed write data.
- rsp_valid  out  NREQ  read data valid, one-cycle strobe.
- rsp_data  out  NREQ*WIDTH  packed read data; slice i is meaningful only when rsp_valid[i] is high.
- ram_ena, ram_enb  out  1  port enables.
- ram_wea, ram_web  out  1  port write enables.
- ram_addra, ram_addrb  out  AW  port addresses.
- ram_dina, ram_dinb  out  WIDTH  port write data.
- ram_oreg_ena, ram_oreg_enb  out  1  output register enables.
- ram_rsta, ram_rstb  out  1  output register resets.
- ram_douta, ram_doutb  in  WIDTH  RAM output data.

Behaviour:
- Reset values:
  - req_ready = 0, rsp_valid = 0, rsp_data = 0.
  - All ram_en/we/oreg_en = 0; ram_addr/din = 0.
  - rr_ptr = 0; all pipeline tags invalid.
  - ram_rsta = ram_rstb = rstb, registered one cycle.
- Arbitration (combinational in cycle T):
  - Scan requesters starting at index rr_ptr, modulo NREQ. The first valid one is winner A; the next valid one after A is winner B.
  - req_ready is high only for winners. It depends combinationally on req_valid, so requesters must not make valid depend on ready.
- Conflict rule: if A and B target the same address and at least one of them is a write, B is not granted that cycle. B keeps valid and retries.
- Pointer update: rr_ptr becomes (last granted index + 1) mod NREQ. It does not change when nothing is granted.
- Issue (edge ending cycle T): the registered RAM port signals carry the winners.
  - Port A: ram_ena = 1, ram_wea = req_we, plus address and data. Port B likewise.
  - An ungranted port has en = 0.
- Tag pipeline: for each port, a tag {valid_read, id} is carried through stages S1 (cycle T+1), S2 (T+2) and S3 (T+3).
  - ram_oreg_ena is high in T+2 iff the port A S2 tag is a valid read; port B likewise with ram_oreg_enb.
- Response:
  - In cycle T+3, rsp_valid[id] = 1 and rsp_data slice id = ram_douta (port A) or ram_doutb (port B). rsp_valid and rsp_data are combinational from the S3 tags and RAM outputs.
  - Read latency is exactly 3 cycles from acceptance, with no backpressure; requesters must sink every response.
  - A and B are always different requesters, so rsp_valid has at most two bits set per cycle.
- Write semantics: a write is committed at the T+1 edge.
  - A read accepted in cycle T+1 or later, to the same address, returns the new data.
  - On a write cycle the RAM port retains its last output; the arbiter ignores it because the tag is not a read.
- Throughput: 2 accesses per cycle sustained when at least 2 requesters are valid with non-conflicting addresses.
- Single requester: the same requester can be granted every cycle, but only on port A.
- Reset mid-operation: all tags are cleared the next edge, so no rsp_valid appears for in-flight reads. In-flight writes already registered to the RAM may complete.

Test Plan:
- Reset, then req0 writes 0xAA at addr 5, then req0 reads addr 5 the next cycle -> rsp_valid[0] exactly 3 cycles after the read is accepted, rsp_data[0] = 0xAA.
- req1 and req2 read addr 3 and 7 in the same cycle (values 0x33, 0x77) -> both req_ready high, ram_ena and ram_enb asserted, both responses 3 cycles later with correct data routed.
- req0 and req1 both write addr 9 in the same cycle with rr_ptr = 0 -> only req0 granted; req1 granted the next cycle; a later read of addr 9 returns req1's data.
- All 4 requesters continuously valid with distinct read addresses -> grant pairs cycle {0,1}, {2,3}, {0,1}…; no starvation over 100 cycles; 2 responses every cycle.
- Single requester req3 streaming reads -> granted every cycle on port A only; enb stays 0.
- Issue 2 reads, assert rstb for 1 cycle at T+1 -> no rsp_valid at T+3; all outputs are at reset values during reset; normal operation resumes afterwards.

Source files
------------

// File: rtl/vbram_port_arbiter_if.sv
// Requester-side bus of the block RAM port arbiter.
//   req_valid/req_ready : per-requester handshake, accepted when both high
//   req_we              : per-requester write select (1 = write)
//   req_addr/req_wdata  : packed per-requester address and write data
//   rsp_valid/rsp_data  : per-requester read-return strobe and packed data
// master = requester side, slave = arbiter side.
interface vbram_port_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 72,
  parameter int AW    = 11
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_we;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ*WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/vbram_port_arbiter.sv
// Shares one true-dual-port block RAM (output register on, 2-cycle read
// latency) among NREQ requesters. Round-robin picks up to two winners per
// cycle: first to port A, second to port B. Reads return 3 cycles after
// acceptance on the issuing requester's rsp slice.
// Ports:
//   clka, rstb            : clock, synchronous active-high reset
//   bus (slave)           : requester handshake and response bus
//   ram_en*/we*/addr*/din*: registered RAM port controls
//   ram_oreg_en*, ram_rst*: output register enable / reset
//   ram_dout*             : RAM output data
module vbram_port_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 72,
  parameter  int DEPTH = 2048,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clka,
  input  logic             rstb,
  vbram_port_arbiter_if.slave bus,
  output logic             ram_ena,
  output logic             ram_enb,
  output logic             ram_wea,
  output logic             ram_web,
  output logic [AW-1:0]    ram_addra,
  output logic [AW-1:0]    ram_addrb,
  output logic [WIDTH-1:0] ram_dina,
  output logic [WIDTH-1:0] ram_dinb,
  output logic             ram_oreg_ena,
  output logic             ram_oreg_enb,
  output logic             ram_rsta,
  output logic             ram_rstb,
  input  logic [WIDTH-1:0] ram_douta,
  input  logic [WIDTH-1:0] ram_doutb
);
  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]   rr_ptr, idx_a, idx_b, last_idx, ptr_nxt;
  logic [IW:0]     scan, inc;
  logic            found_a, found_b, grant_b, conflict;
  logic [AW-1:0]   addr_a, addr_b;
  logic            we_a, we_b;
  logic [WIDTH-1:0] wdata_a, wdata_b;
  logic [NREQ-1:0] rdy;

  // read tags per stage: valid-read flag plus requester id
  logic            s1_a_rd, s2_a_rd, s3_a_rd, s1_b_rd, s2_b_rd, s3_b_rd;
  logic [IW-1:0]   s1_a_id, s2_a_id, s3_a_id, s1_b_id, s2_b_id, s3_b_id;

  logic [NREQ-1:0]       rsp_v;
  logic [NREQ*WIDTH-1:0] rsp_d;

  // Scan from rr_ptr with wraparound; nothing wins while in reset.
  always_comb begin
    found_a = 1'b0;
    found_b = 1'b0;
    idx_a   = '0;
    idx_b   = '0;
    scan    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, rr_ptr} + (IW+1)'(k);
      if (scan >= (IW+1)'(NREQ)) scan = scan - (IW+1)'(NREQ);
      if (bus.req_valid[scan[IW-1:0]] && !rstb) begin
        if (!found_a) begin
          found_a = 1'b1;
          idx_a   = scan[IW-1:0];
        end else if (!found_b) begin
          found_b = 1'b1;
          idx_b   = scan[IW-1:0];
        end
      end
    end
  end

  assign addr_a  = bus.req_addr[idx_a*AW +: AW];
  assign addr_b  = bus.req_addr[idx_b*AW +: AW];
  assign we_a    = bus.req_we[idx_a];
  assign we_b    = bus.req_we[idx_b];
  assign wdata_a = bus.req_wdata[idx_a*WIDTH +: WIDTH];
  assign wdata_b = bus.req_wdata[idx_b*WIDTH +: WIDTH];

  // Same-address pair with a write would race inside the RAM; B retries.
  assign conflict = (addr_a == addr_b) && (we_a || we_b);
  assign grant_b  = found_b && !conflict;

  always_comb begin
    rdy = '0;
    if (found_a) rdy[idx_a] = 1'b1;
    if (grant_b) rdy[idx_b] = 1'b1;
  end
  assign bus.req_ready = rdy;

  assign last_idx = grant_b ? idx_b : idx_a;
  assign inc      = {1'b0, last_idx} + (IW+1)'(1);
  assign ptr_nxt  = (inc == (IW+1)'(NREQ)) ? '0 : inc[IW-1:0];

  always_ff @(posedge clka) begin
    if (rstb) begin
      rr_ptr    <= '0;
      ram_ena   <= 1'b0;
      ram_wea   <= 1'b0;
      ram_addra <= '0;
      ram_dina  <= '0;
      ram_enb   <= 1'b0;
      ram_web   <= 1'b0;
      ram_addrb <= '0;
      ram_dinb  <= '0;
      s1_a_rd   <= 1'b0;
      s2_a_rd   <= 1'b0;
      s3_a_rd   <= 1'b0;
      s1_b_rd   <= 1'b0;
      s2_b_rd   <= 1'b0;
      s3_b_rd   <= 1'b0;
      s1_a_id   <= '0;
      s2_a_id   <= '0;
      s3_a_id   <= '0;
      s1_b_id   <= '0;
      s2_b_id   <= '0;
      s3_b_id   <= '0;
    end else begin
      if (found_a) rr_ptr <= ptr_nxt;
      ram_ena   <= found_a;
      ram_wea   <= found_a & we_a;
      ram_addra <= addr_a;
      ram_dina  <= wdata_a;
      ram_enb   <= grant_b;
      ram_web   <= grant_b & we_b;
      ram_addrb <= addr_b;
      ram_dinb  <= wdata_b;
      s1_a_rd   <= found_a & ~we_a;
      s1_a_id   <= idx_a;
      s1_b_rd   <= grant_b & ~we_b;
      s1_b_id   <= idx_b;
      s2_a_rd   <= s1_a_rd;
      s2_a_id   <= s1_a_id;
      s2_b_rd   <= s1_b_rd;
      s2_b_id   <= s1_b_id;
      s3_a_rd   <= s2_a_rd;
      s3_a_id   <= s2_a_id;
      s3_b_rd   <= s2_b_rd;
      s3_b_id   <= s2_b_id;
    end
  end

  // Output-register resets follow rstb one cycle late.
  always_ff @(posedge clka) begin
    ram_rsta <= rstb;
    ram_rstb <= rstb;
  end

  // Data sits in the RAM latch during S2, so the output register loads then.
  assign ram_oreg_ena = s2_a_rd;
  assign ram_oreg_enb = s2_b_rd;

  always_comb begin
    rsp_v = '0;
    rsp_d = '0;
    if (!rstb) begin
      if (s3_a_rd) begin
        rsp_v[s3_a_id]                  = 1'b1;
        rsp_d[s3_a_id*WIDTH +: WIDTH]   = ram_douta;
      end
      if (s3_b_rd) begin
        rsp_v[s3_b_id]                  = 1'b1;
        rsp_d[s3_b_id*WIDTH +: WIDTH]   = ram_doutb;
      end
    end
  end
  assign bus.rsp_valid = rsp_v;
  assign bus.rsp_data  = rsp_d;
endmodule

// File: tb/tb_vbram_port_arbiter.sv
module tb_vbram_port_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 72;
  localparam int DEPTH = 2048;
  localparam int AW    = 11;
  localparam int MAXC  = 4096;

  typedef struct {
    bit               en;
    bit               we;
    int               addr;
    logic [WIDTH-1:0] din;
  } port_t;

  typedef struct {
    int               due;
    int               id;
    logic [WIDTH-1:0] data;
  } rsp_t;

  logic clka = 1'b0;
  logic rstb;
  always #5 clka = ~clka;

  vbram_port_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .AW(AW)) bus ();

  logic             ram_ena, ram_enb, ram_wea, ram_web;
  logic [AW-1:0]    ram_addra, ram_addrb;
  logic [WIDTH-1:0] ram_dina, ram_dinb, ram_douta, ram_doutb;
  logic             ram_oreg_ena, ram_oreg_enb, ram_rsta, ram_rstb;

  vbram_port_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clka(clka), .rstb(rstb), .bus(bus.slave),
    .ram_ena(ram_ena), .ram_enb(ram_enb), .ram_wea(ram_wea), .ram_web(ram_web),
    .ram_addra(ram_addra), .ram_addrb(ram_addrb),
    .ram_dina(ram_dina), .ram_dinb(ram_dinb),
    .ram_oreg_ena(ram_oreg_ena), .ram_oreg_enb(ram_oreg_enb),
    .ram_rsta(ram_rsta), .ram_rstb(ram_rstb),
    .ram_douta(ram_douta), .ram_doutb(ram_doutb)
  );

  // Block RAM: no-change mode, latch stage plus output register.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] lat_a, lat_b;
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    lat_a = '0; lat_b = '0; ram_douta = '0; ram_doutb = '0;
  end
  always @(posedge clka) begin
    if (ram_ena === 1'b1) begin
      if (ram_wea) mem[ram_addra] <= ram_dina;
      else         lat_a <= mem[ram_addra];
    end
    if (ram_enb === 1'b1) begin
      if (ram_web) mem[ram_addrb] <= ram_dinb;
      else         lat_b <= mem[ram_addrb];
    end
    if (ram_rsta === 1'b1)          ram_douta <= '0;
    else if (ram_oreg_ena === 1'b1) ram_douta <= lat_a;
    if (ram_rstb === 1'b1)          ram_doutb <= '0;
    else if (ram_oreg_enb === 1'b1) ram_doutb <= lat_b;
  end

  // Reference model state
  logic [WIDTH-1:0] mdl_mem [DEPTH];
  int    ptr;
  rsp_t  pend[$];
  port_t hist_a [MAXC];
  port_t hist_b [MAXC];
  bit    tag_a  [MAXC];
  bit    tag_b  [MAXC];
  bit    rst_hist [MAXC];
  int    gcnt [NREQ];
  int    cyc;
  int    n_chk, n_err;

  // Stimulus for the next cycle
  logic [NREQ-1:0]  s_valid, s_we;
  int               s_addr  [NREQ];
  logic [WIDTH-1:0] s_wdata [NREQ];
  bit               s_rst;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    int               order[$];
    int               a, b, i;
    logic [NREQ-1:0]  exp_rdy, exp_v;
    rsp_t             r;
    port_t            pa, pb;
    rstb = s_rst;
    for (int q = 0; q < NREQ; q++) begin
      bus.req_valid[q]               = s_valid[q];
      bus.req_we[q]                  = s_we[q];
      bus.req_addr[q*AW +: AW]       = AW'(s_addr[q]);
      bus.req_wdata[q*WIDTH +: WIDTH] = s_wdata[q];
    end
    #1;
    a = -1; b = -1;
    if (!s_rst) begin
      for (int k = 0; k < NREQ; k++) begin
        i = (ptr + k) % NREQ;
        if (s_valid[i]) order.push_back(i);
      end
      if (order.size() >= 1) a = order[0];
      if (order.size() >= 2) begin
        b = order[1];
        if (s_addr[a] == s_addr[b] && (s_we[a] || s_we[b])) b = -1;
      end
    end
    exp_rdy = '0;
    if (a >= 0) exp_rdy[a] = 1'b1;
    if (b >= 0) exp_rdy[b] = 1'b1;
    chk("req_ready", bus.req_ready, exp_rdy);

    exp_v = '0;
    if (s_rst) pend.delete();
    while (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      exp_v[r.id] = 1'b1;
      chk("rsp_data", bus.rsp_data[r.id*WIDTH +: WIDTH], r.data);
    end
    chk("rsp_valid", bus.rsp_valid, exp_v);

    if (cyc >= 1) begin
      chk("ram_ena", ram_ena, hist_a[cyc-1].en);
      if (hist_a[cyc-1].en) begin
        chk("ram_wea", ram_wea, hist_a[cyc-1].we);
        chk("ram_addra", ram_addra, hist_a[cyc-1].addr);
        if (hist_a[cyc-1].we) chk("ram_dina", ram_dina, hist_a[cyc-1].din);
      end
      chk("ram_enb", ram_enb, hist_b[cyc-1].en);
      if (hist_b[cyc-1].en) begin
        chk("ram_web", ram_web, hist_b[cyc-1].we);
        chk("ram_addrb", ram_addrb, hist_b[cyc-1].addr);
        if (hist_b[cyc-1].we) chk("ram_dinb", ram_dinb, hist_b[cyc-1].din);
      end
      chk("ram_rsta", ram_rsta, rst_hist[cyc-1]);
      chk("ram_rstb", ram_rstb, rst_hist[cyc-1]);
    end
    if (cyc >= 2) begin
      chk("oreg_a", ram_oreg_ena, tag_a[cyc-2]);
      chk("oreg_b", ram_oreg_enb, tag_b[cyc-2]);
    end

    pa = '{en: 1'b0, we: 1'b0, addr: 0, din: '0};
    pb = pa;
    if (a >= 0) pa = '{en: 1'b1, we: s_we[a], addr: s_addr[a], din: s_wdata[a]};
    if (b >= 0) pb = '{en: 1'b1, we: s_we[b], addr: s_addr[b], din: s_wdata[b]};
    hist_a[cyc]   = pa;
    hist_b[cyc]   = pb;
    tag_a[cyc]    = pa.en && !pa.we;
    tag_b[cyc]    = pb.en && !pb.we;
    rst_hist[cyc] = s_rst;
    if (s_rst && cyc >= 1) begin
      tag_a[cyc-1] = 1'b0;
      tag_b[cyc-1] = 1'b0;
    end
    if (tag_a[cyc]) pend.push_back('{due: cyc+3, id: a, data: mdl_mem[pa.addr]});
    if (tag_b[cyc]) pend.push_back('{due: cyc+3, id: b, data: mdl_mem[pb.addr]});
    if (pa.en && pa.we) mdl_mem[pa.addr] = pa.din;
    if (pb.en && pb.we) mdl_mem[pb.addr] = pb.din;
    if (a >= 0) gcnt[a]++;
    if (b >= 0) gcnt[b]++;
    if (s_rst)       ptr = 0;
    else if (b >= 0) ptr = (b + 1) % NREQ;
    else if (a >= 0) ptr = (a + 1) % NREQ;

    @(posedge clka);
    @(negedge clka);
    cyc++;
  endtask

  task automatic clear_req();
    s_valid = '0;
    s_we    = '0;
  endtask

  task automatic set_req(input int i, input bit we, input int addr, input logic [WIDTH-1:0] d);
    s_valid[i] = 1'b1;
    s_we[i]    = we;
    s_addr[i]  = addr;
    s_wdata[i] = d;
  endtask

  task automatic idle(input int n);
    clear_req();
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0; ptr = 0;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
    for (int i = 0; i < NREQ; i++) begin
      s_addr[i] = 0; s_wdata[i] = '0; gcnt[i] = 0;
    end
    clear_req();

    // Reset held for several cycles, with a requester trying to get in
    s_rst = 1'b1;
    set_req(1, 1'b0, 4, '0);
    repeat (3) step();
    chk("rst_wea", {ram_wea, ram_web}, 2'b00);
    chk("rst_addr", {ram_addra, ram_addrb}, '0);
    chk("rst_din", {ram_dina, ram_dinb}, '0);
    chk("rst_rsp_data", bus.rsp_data, '0);
    s_rst = 1'b0;
    idle(2);

    // Write then read back through requester 0
    set_req(0, 1'b1, 5, 72'hAA);
    step();
    clear_req();
    set_req(0, 1'b0, 5, '0);
    step();
    idle(4);

    // Two requesters in one cycle: preload then dual read
    set_req(1, 1'b1, 3, 72'h33);
    set_req(2, 1'b1, 7, 72'h77);
    step();
    clear_req();
    set_req(1, 1'b0, 3, '0);
    set_req(2, 1'b0, 7, '0);
    step();
    chk("dual_issue", {ram_ena, ram_enb}, 2'b11);
    idle(4);

    // Reset one cycle after two reads are accepted: responses dropped
    set_req(0, 1'b0, 5, '0);
    set_req(1, 1'b0, 3, '0);
    step();
    clear_req();
    set_req(2, 1'b0, 7, '0);
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    idle(4);

    // Same-address write conflict with the pointer at 0
    set_req(0, 1'b1, 9, 72'h900);
    set_req(1, 1'b1, 9, 72'h911);
    step();
    s_valid[0] = 1'b0;
    step();
    clear_req();
    set_req(2, 1'b0, 9, '0);
    step();
    idle(4);

    // All four valid, distinct read addresses
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    set_req(0, 1'b0, 3, '0);
    set_req(1, 1'b0, 5, '0);
    set_req(2, 1'b0, 7, '0);
    set_req(3, 1'b0, 9, '0);
    repeat (100) step();
    for (int i = 0; i < NREQ; i++) chk($sformatf("fair_cnt%0d", i), gcnt[i], 50);
    idle(4);

    // Single requester streaming reads
    clear_req();
    for (int k = 0; k < 20; k++) begin
      set_req(3, 1'b0, int'($urandom_range(0, 15)), '0);
      step();
    end
    idle(4);

    // Random traffic over a small address window, occasional reset
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        s_valid[i] = ($urandom_range(0, 3) != 0);
        s_we[i]    = ($urandom_range(0, 2) == 0);
        s_addr[i]  = int'($urandom_range(0, 7));
        s_wdata[i] = WIDTH'({$urandom(), $urandom(), $urandom()});
      end
      s_rst = ($urandom_range(0, 149) == 0);
      step();
    end
    s_rst = 1'b0;
    idle(5);
    chk("drain", pend.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
